// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall-bus layout, stall masks, flush levels and
// sequencer state codes for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Stall bus layout {wb,mem,ex,id,if,pc}; bit set = hold that stage register
    localparam int StallBusW = 6;
    typedef logic [StallBusW-1:0] stall_bus_t;

    // A request from a stage holds that stage and everything upstream of it
    localparam stall_bus_t StallNone = 6'b000000;
    localparam stall_bus_t StallIF   = 6'b000011;
    localparam stall_bus_t StallID   = 6'b000111;
    localparam stall_bus_t StallEX   = 6'b001111;
    localparam stall_bus_t StallMEM  = 6'b011111;

    localparam logic FlushEnable  = 1'b1;
    localparam logic FlushDisable = 1'b0;

    // Sequencer state codes for the EX multi-cycle FSM
    typedef enum logic [1:0] {
        PipeCtrlIdle  = 2'd0,
        PipeCtrlMulti = 2'd1,
        PipeCtrlDone  = 2'd2
    } pipe_state_e;

    // Priority encoder: the deepest requesting stage wins (mem > ex > id > if)
    function automatic stall_bus_t stall_encode(input logic mem_req,
                                                input logic ex_req,
                                                input logic id_req,
                                                input logic if_req);
        stall_bus_t mask;
        mask = StallNone;
        if (mem_req) begin
            mask = StallMEM;
        end else if (ex_req) begin
            mask = StallEX;
        end else if (id_req) begin
            mask = StallID;
        end else if (if_req) begin
            mask = StallIF;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pipe_ctrl_ex_multi_timer.sv
// pipe_ctrl_ex_multi_timer: down-counter that times an EX multi-cycle op.
// load captures N-1 (N=0 behaves like N=1), abort clears the count, and
// last flags the final MULTI cycle so the FSM can move to DONE.
module pipe_ctrl_ex_multi_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] n,
    input  logic             abort,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] load_val;

    assign load_val = (n == '0) ? '0 : (n - CNT_W'(1));

    // The start cycle already stalls EX once, so MULTI ends when the count
    // is about to reach 1; this keeps an N-cycle op stalling exactly N-1 cycles.
    assign last = (cnt_reg == CNT_W'(2));

    // Count register: abort wins over load, otherwise count down to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (abort) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges stage stall requests, times EX multi-cycle ops and turns
// exception/redirect requests into a flush. Optional feature macro:
// PIPE_CTRL_PERF_EN builds saturating stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallreq_if,
    input  logic                 stallreq_id,
    input  logic                 stallreq_ex,
    input  logic                 stallreq_mem,
    input  logic                 ex_multi_start,
    input  logic [CNT_W-1:0]     ex_multi_cycles,
    input  logic                 flush_req,
    output logic [StallBusW-1:0] stall,
    output logic                 flush,
    output logic                 ex_busy,
    output logic                 ex_multi_done,
    output logic [PERF_W-1:0]    perf_stall_cnt,
    output logic [PERF_W-1:0]    perf_flush_cnt
);

    pipe_state_e state_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        timer_last;
    logic        timer_load;
    logic        start_idle;
    logic        ex_req_int;
    stall_bus_t  stall_next;

    // A start is honoured only in IDLE and never alongside a flush
    assign start_idle = (state_reg == PipeCtrlIdle) && ex_multi_start;
    assign timer_load = start_idle && !flush_req;

    // Internal EX hold: the whole MULTI phase plus the start cycle of a long op
    assign ex_req_int = (state_reg == PipeCtrlMulti) ||
                        (start_idle && (ex_multi_cycles > CNT_W'(1)));

    pipe_ctrl_ex_multi_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .n     (ex_multi_cycles),
        .abort (flush_req),
        .last  (timer_last)
    );

    // Stall vector: zero in reset and during a flush, else deepest request wins
    always_comb begin
        stall_next = StallNone;
        if (rst && !flush_req) begin
            stall_next = stall_encode(stallreq_mem, stallreq_ex | ex_req_int,
                                      stallreq_id, stallreq_if);
        end
    end

    assign stall = stall_next;
    assign flush = (rst && flush_req) ? FlushEnable : FlushDisable;

    // A flush in the DONE cycle squashes the result write as well
    assign ex_busy       = busy_reg;
    assign ex_multi_done = done_reg && !flush_req;

    // Multi-cycle sequencer with registered busy/done outputs.
    // An N=2 op is fully covered by its start-cycle stall, so it skips MULTI.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= PipeCtrlIdle;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (flush_req) begin
            state_reg <= PipeCtrlIdle;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                PipeCtrlIdle: begin
                    if (ex_multi_start) begin
                        if (ex_multi_cycles > CNT_W'(2)) begin
                            state_reg <= PipeCtrlMulti;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end else begin
                            state_reg <= PipeCtrlDone;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                PipeCtrlMulti: begin
                    if (timer_last) begin
                        state_reg <= PipeCtrlDone;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                PipeCtrlDone: begin
                    state_reg <= PipeCtrlIdle;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= PipeCtrlIdle;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_reg;
    logic [PERF_W-1:0] perf_flush_reg;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if ((stall_next != StallNone) && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + PERF_W'(1);
            end
            if ((flush == FlushEnable) && (perf_flush_reg != '1)) begin
                perf_flush_reg <= perf_flush_reg + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = perf_stall_reg;
    assign perf_flush_cnt = perf_flush_reg;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        ex_multi_start;
    logic [5:0]  ex_multi_cycles;
    logic        flush_req;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_busy;
    logic        ex_multi_done;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int errors = 0;
    int checks = 0;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] ExpPerfStall = 32'd7;
    localparam logic [31:0] ExpPerfFlush = 32'd2;
`else
    localparam logic [31:0] ExpPerfStall = 32'd0;
    localparam logic [31:0] ExpPerfFlush = 32'd0;
`endif

    pipe_ctrl #(
        .CNT_W  (6),
        .PERF_W (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if     (stallreq_if),
        .stallreq_id     (stallreq_id),
        .stallreq_ex     (stallreq_ex),
        .stallreq_mem    (stallreq_mem),
        .ex_multi_start  (ex_multi_start),
        .ex_multi_cycles (ex_multi_cycles),
        .flush_req       (flush_req),
        .stall           (stall),
        .flush           (flush),
        .ex_busy         (ex_busy),
        .ex_multi_done   (ex_multi_done),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the four main outputs at once
    task automatic chk4(input string tag, input logic [5:0] s, input logic f,
                        input logic b, input logic d);
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, s});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, ".busy"},  {31'd0, ex_busy}, {31'd0, b});
        chk({tag, ".done"},  {31'd0, ex_multi_done}, {31'd0, d});
        $display("step %-12s stall=%b flush=%b busy=%b done=%b", tag, stall, flush, ex_busy, ex_multi_done);
    endtask

    task automatic set_req(input logic i_f, input logic i_d, input logic i_e, input logic i_m);
        stallreq_if  = i_f;
        stallreq_id  = i_d;
        stallreq_ex  = i_e;
        stallreq_mem = i_m;
    endtask

    task automatic next_step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        set_req(1, 1, 1, 1);
        ex_multi_start  = 1'b0;
        ex_multi_cycles = 6'd0;
        flush_req       = 1'b1;

        // Reset holds every output at zero even with all requests high
        next_step(); #1;
        chk4("rst", 6'b000000, 0, 0, 0);
        chk("rst.perf_s", perf_stall_cnt, 32'd0);
        chk("rst.perf_f", perf_flush_cnt, 32'd0);

        // Release reset: mem request dominates
        next_step(); flush_req = 1'b0; rst = 1'b1; #1;
        chk4("rst_rel", 6'b011111, 0, 0, 0);

        // Priority encoding, all combinational
        next_step(); set_req(1, 1, 0, 0); #1;
        chk4("pri_id_if", 6'b000111, 0, 0, 0);
        next_step(); set_req(1, 1, 0, 1); #1;
        chk4("pri_mem", 6'b011111, 0, 0, 0);
        next_step(); set_req(0, 0, 0, 0); #1;
        chk4("pri_clr", 6'b000000, 0, 0, 0);
        next_step(); set_req(1, 0, 1, 0); #1;
        chk4("pri_ex", 6'b001111, 0, 0, 0);
        next_step(); set_req(1, 0, 0, 0); #1;
        chk4("pri_if", 6'b000011, 0, 0, 0);
        next_step(); set_req(0, 0, 0, 0); #1;

        // N=5: stall cycles 1-4, busy 2-4, done on 5; restart on 3 ignored
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd5; #1;
        chk4("m5_c1", 6'b001111, 0, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("m5_c2", 6'b001111, 0, 1, 0);
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd3; #1;
        chk4("m5_c3", 6'b001111, 0, 1, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("m5_c4", 6'b001111, 0, 1, 0);
        next_step(); #1;
        chk4("m5_c5", 6'b000000, 0, 0, 1);
        next_step(); #1;
        chk4("m5_c6", 6'b000000, 0, 0, 0);

        // N=4 with a mem wait during MULTI/DONE: mem mask wins, done still pulses
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd4; #1;
        chk4("m4_c1", 6'b001111, 0, 0, 0);
        next_step(); ex_multi_start = 0; stallreq_mem = 1; #1;
        chk4("m4_c2", 6'b011111, 0, 1, 0);
        next_step(); #1;
        chk4("m4_c3", 6'b011111, 0, 1, 0);
        next_step(); #1;
        chk4("m4_c4", 6'b011111, 0, 0, 1);
        next_step(); stallreq_mem = 0; #1;
        chk4("m4_c5", 6'b000000, 0, 0, 0);

        // N=10 aborted by flush on cycle 3, then a new N=3 op is accepted
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd10; #1;
        chk4("fl_c1", 6'b001111, 0, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("fl_c2", 6'b001111, 0, 1, 0);
        next_step(); flush_req = 1; #1;
        chk4("fl_c3", 6'b000000, 1, 1, 0);
        next_step(); flush_req = 0; #1;
        chk4("fl_c4", 6'b000000, 0, 0, 0);
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd3; #1;
        chk4("fl_r1", 6'b001111, 0, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("fl_r2", 6'b001111, 0, 1, 0);
        next_step(); #1;
        chk4("fl_r3", 6'b000000, 0, 0, 1);

        // Flush together with start drops the start; held flush repeats
        next_step(); flush_req = 1; ex_multi_start = 1; ex_multi_cycles = 6'd5; #1;
        chk4("fs_c1", 6'b000000, 1, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("fs_c2", 6'b000000, 1, 0, 0);
        next_step(); flush_req = 0; #1;
        chk4("fs_c3", 6'b000000, 0, 0, 0);

        // Short ops: N=1 and N=0 never stall, done next cycle
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd1; #1;
        chk4("n1_c1", 6'b000000, 0, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("n1_c2", 6'b000000, 0, 0, 1);
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd0; #1;
        chk4("n0_c1", 6'b000000, 0, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("n0_c2", 6'b000000, 0, 0, 1);
        next_step(); #1;
        chk4("n0_c3", 6'b000000, 0, 0, 0);

        // N=8 with asynchronous reset on cycle 4
        next_step(); ex_multi_start = 1; ex_multi_cycles = 6'd8; #1;
        chk4("ar_c1", 6'b001111, 0, 0, 0);
        next_step(); ex_multi_start = 0; #1;
        chk4("ar_c2", 6'b001111, 0, 1, 0);
        next_step(); #1;
        chk4("ar_c3", 6'b001111, 0, 1, 0);
        next_step(); stallreq_mem = 1; rst = 0; #1;
        chk4("ar_c4", 6'b000000, 0, 0, 0);
        next_step(); stallreq_mem = 0; rst = 1; #1;
        chk4("ar_c5", 6'b000000, 0, 0, 0);
        chk("ar.perf_s", perf_stall_cnt, 32'd0);

        // Perf: 7 stalled cycles then 2 flush cycles after the fresh reset
        for (int i = 0; i < 7; i++) begin
            next_step(); stallreq_if = 1; #1;
        end
        next_step(); stallreq_if = 0; flush_req = 1; #1;
        next_step(); #1;
        next_step(); flush_req = 0; #1;
        chk("perf_stall", perf_stall_cnt, ExpPerfStall);
        chk("perf_flush", perf_flush_cnt, ExpPerfFlush);
        $display("step perf         stall_cnt=%0d flush_cnt=%0d", perf_stall_cnt, perf_flush_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
